// File: rtl/neuron_grid_n.sv
// Serial time-domain neuron grid: one shared pulse generator drives N signed
// accumulators; results are shifted, saturated and optionally rectified on output.
module neuron_grid_n #(
  parameter int N     = 8,
  parameter int DW    = 8,
  parameter int AW    = 24,
  parameter int SHIFT = 0,
  parameter int RELU  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   din,
  input  logic [N*DW-1:0] win,
  input  logic [N*DW-1:0] bias,
  input  logic            last,
  output logic            tac_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT
  } state_t;

  state_t               state;
  logic [DW-1:0]        cnt;
  logic                 sx;
  logic                 last_r;
  logic                 first;
  logic [DW-1:0]        wmag [N];
  logic                 sw   [N];
  logic signed [AW-1:0] acc  [N];

  logic                 accept;
  logic [DW-1:0]        din_mag;
  logic [DW-1:0]        win_mag  [N];
  logic signed [AW-1:0] acc_next [N];
  logic [N*DW-1:0]      dout_next;

  // Adds +/-m to a, clamping at the AW-bit signed limits instead of wrapping.
  function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                   input logic neg,
                                                   input logic [DW-1:0] m);
    logic signed [AW:0] d;
    logic signed [AW:0] s;
    d = signed'({{(AW+1-DW){1'b0}}, m});
    s = {a[AW-1], a} + (neg ? -d : d);
    if (s[AW] != s[AW-1])
      return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    return s[AW-1:0];
  endfunction

  // Scale, clamp to DW bits and rectify one accumulator.
  function automatic logic [DW-1:0] to_out(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] y;
    y = a >>> SHIFT;
    if (RELU != 0 && y[AW-1])
      return '0;
    if (y[AW-1:DW-1] != {(AW-DW+1){y[AW-1]}})
      return y[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return y[DW-1:0];
  endfunction

  assign accept  = in_valid && in_ready;
  assign din_mag = din[DW-1] ? (~din + 1'b1) : din;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    dout_next = '0;
    for (int i = 0; i < N; i++) begin
      win_mag[i]  = win[i*DW+DW-1] ? (~win[i*DW +: DW] + 1'b1) : win[i*DW +: DW];
      acc_next[i] = acc[i];
      if (state == S_IDLE && accept && first)
        acc_next[i] = {{(AW-DW){bias[i*DW+DW-1]}}, bias[i*DW +: DW]};
      else if (state == S_RUN)
        acc_next[i] = sat_add(acc[i], sx ^ sw[i], wmag[i]);
      dout_next[i*DW +: DW] = to_out(acc_next[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking is kept to combinational code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      tac_out   <= 1'b0;
      dout      <= '0;
      cnt       <= '0;
      sx        <= 1'b0;
      last_r    <= 1'b0;
      first     <= 1'b1;
      // NOTE: accumulators and operand registers are reset too, so an aborted inference leaves no residue.
      for (int i = 0; i < N; i++) begin
        acc[i]  <= '0;
        wmag[i] <= '0;
        sw[i]   <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sx     <= din[DW-1];
            last_r <= last;
            first  <= 1'b0;
            for (int i = 0; i < N; i++) begin
              wmag[i] <= win_mag[i];
              sw[i]   <= win[i*DW+DW-1];
              acc[i]  <= acc_next[i];
            end
            if (din_mag != '0) begin
              state    <= S_RUN;
              cnt      <= din_mag;
              tac_out  <= 1'b1;
              in_ready <= 1'b0;
            end else if (last) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              dout      <= dout_next;
            end
          end
        end
        S_RUN: begin
          for (int i = 0; i < N; i++)
            acc[i] <= acc_next[i];
          cnt <= cnt - 1'b1;
          if (cnt == DW'(1)) begin
            tac_out <= 1'b0;
            if (last_r) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              dout      <= dout_next;
            end else begin
              state    <= S_IDLE;
              in_ready <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            first     <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_grid_n.sv
// Directed plus light random bench for neuron_grid_n; three instances cover
// RELU on/off and SHIFT=2, checked against a product-form reference model.
module tb_neuron_grid_n;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   din;
  logic [N*DW-1:0] win;
  logic [N*DW-1:0] bias_v;
  logic            last;
  logic            out_ready;

  logic            ir_a, ir_b, ir_c;
  logic            tac_a, tac_b, tac_c;
  logic            ov_a, ov_b, ov_c;
  logic [N*DW-1:0] dout_a, dout_b, dout_c;

  neuron_grid_n #(.N(N), .DW(DW), .AW(AW), .SHIFT(0), .RELU(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .din(din), .win(win),
    .bias(bias_v), .last(last), .tac_out(tac_a), .out_valid(ov_a), .out_ready(out_ready),
    .dout(dout_a));
  neuron_grid_n #(.N(N), .DW(DW), .AW(AW), .SHIFT(0), .RELU(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .din(din), .win(win),
    .bias(bias_v), .last(last), .tac_out(tac_b), .out_valid(ov_b), .out_ready(out_ready),
    .dout(dout_b));
  neuron_grid_n #(.N(N), .DW(DW), .AW(AW), .SHIFT(2), .RELU(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .din(din), .win(win),
    .bias(bias_v), .last(last), .tac_out(tac_c), .out_valid(ov_c), .out_ready(out_ready),
    .dout(dout_c));

  always #5 clk = ~clk;

  typedef struct {
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
    logic [N*DW-1:0] c;
  } exp_t;

  exp_t               sb[$];
  int                 n_checks = 0;
  int                 n_fail   = 0;
  logic signed [DW-1:0] wv [N];
  logic signed [DW-1:0] bv [N];
  longint             m_acc [N];
  bit                 m_first = 1'b1;

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sat_aw(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (AW-1)) - 1;
    lo = -(longint'(1) <<< (AW-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [DW-1:0] model_out(input longint a, input int sh, input bit relu);
    longint y;
    y = a >>> sh;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    if (relu && y < 0) y = 0;
    return y[DW-1:0];
  endfunction

  task automatic model_accept(input int d, input bit l);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (m_first) m_acc[i] = longint'(bv[i]);
      m_acc[i] = sat_aw(m_acc[i] + longint'(d) * longint'(wv[i]));
    end
    m_first = 1'b0;
    if (l) begin
      for (int i = 0; i < N; i++) begin
        e.a[i*DW +: DW] = model_out(m_acc[i], 0, 1'b1);
        e.b[i*DW +: DW] = model_out(m_acc[i], 0, 1'b0);
        e.c[i*DW +: DW] = model_out(m_acc[i], 2, 1'b1);
      end
      sb.push_back(e);
      m_first = 1'b1;
    end
  endtask

  task automatic clear_vec();
    for (int i = 0; i < N; i++) begin
      wv[i] = '0;
      bv[i] = '0;
    end
  endtask

  // Present one sample at the current negedge and hold until the accepting edge.
  task automatic accept_only(input int d, input bit l);
    int k;
    k = 0;
    while (ir_a !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", {ir_a, ir_b, ir_c}, 3'b111);
    din = DW'(d);
    for (int i = 0; i < N; i++) begin
      win[i*DW +: DW]    = wv[i];
      bias_v[i*DW +: DW] = bv[i];
    end
    last     = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last     = 1'b0;
    din      = DW'($urandom);
    win      = {$urandom, $urandom};
    bias_v   = {$urandom, $urandom};
  endtask

  task automatic send(input int d, input bit l);
    int mag;
    mag = (d < 0) ? -d : d;
    accept_only(d, l);
    model_accept(d, l);
    for (int c = 1; c <= mag; c++) begin
      @(negedge clk);
      chk("run_tac_ready", {tac_a, tac_b, tac_c, ir_a, ir_b, ir_c}, 6'b111_000);
    end
    @(negedge clk);
    chk("after_run", {tac_a, tac_b, tac_c, ir_a, ir_b, ir_c, ov_a, ov_b, ov_c},
        l ? 9'b000_000_111 : 9'b000_111_000);
  endtask

  // Optionally stall the consumer, then complete the handshake and score the result.
  task automatic get_result(input int hold);
    exp_t e;
    chk("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb[0];
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk("hold_flags", {ov_a, ov_b, ov_c, ir_a, ir_b, ir_c}, 6'b111_000);
      chk("hold_dout_a", dout_a, e.a);
    end
    chk("out_valid", {ov_a, ov_b, ov_c}, 3'b111);
    e = sb.pop_front();
    chk("dout_relu", dout_a, e.a);
    chk("dout_norelu", dout_b, e.b);
    chk("dout_shift2", dout_c, e.c);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_handshake", {ov_a, ov_b, ov_c, ir_a, ir_b, ir_c}, 6'b000_111);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; last = 1'b0;
    din = '0; win = '0; bias_v = '0;
    clear_vec();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_flags", {ir_a, ir_b, ir_c, ov_a, ov_b, ov_c, tac_a, tac_b, tac_c}, 9'b111_000_000);
    chk("reset_dout", dout_a | dout_b | dout_c, '0);

    // Single sample: 3*5+2=17, 3*(-4)=-12.
    wv[0] = 8'sd5; bv[0] = 8'sd2; wv[1] = -8'sd4; bv[1] = 8'sd0;
    send(3, 1'b1);
    get_result(0);

    // Three-sample inference with a zero sample last: -5+30-20=5.
    clear_vec();
    wv[0] = 8'sd10; bv[0] = -8'sd5; wv[2] = 8'sd7; bv[2] = 8'sd1; wv[5] = -8'sd3;
    send(3, 1'b0);
    send(-2, 1'b0);
    send(0, 1'b1);
    get_result(0);

    // Output saturation in both directions.
    clear_vec();
    wv[0] = 8'sd127;
    for (int s = 0; s < 4; s++) send(-128, s == 3);
    get_result(0);
    wv[0] = -8'sd127;
    for (int s = 0; s < 4; s++) send(-128, s == 3);
    get_result(0);

    // Back-pressure, then a fresh inference that must reload the bias.
    clear_vec();
    wv[0] = 8'sd3; bv[0] = 8'sd7; wv[3] = -8'sd9; bv[3] = -8'sd20;
    send(5, 1'b1);
    get_result(6);
    bv[0] = -8'sd1;
    send(2, 1'b1);
    get_result(0);

    // Reset mid-RUN aborts the inference.
    clear_vec();
    wv[0] = 8'sd50; bv[0] = 8'sd40; wv[4] = -8'sd60;
    accept_only(100, 1'b1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun_reset_flags", {ir_a, ir_b, ir_c, ov_a, ov_b, ov_c, tac_a, tac_b, tac_c},
        9'b111_000_000);
    chk("midrun_reset_dout", dout_a | dout_b | dout_c, '0);
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    m_first = 1'b1;
    clear_vec();
    wv[0] = 8'sd1;
    send(1, 1'b1);
    get_result(0);

    // Shifted output: 10*10+3=103, >>>2 gives 25.
    clear_vec();
    wv[0] = 8'sd10; bv[0] = 8'sd3;
    send(10, 1'b1);
    get_result(0);

    // A few random multi-sample inferences.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        wv[i] = DW'($urandom);
        bv[i] = DW'($urandom);
      end
      ns = $urandom_range(1, 3);
      for (int s = 0; s < ns; s++) send(int'($urandom_range(0, 40)) - 20, s == ns - 1);
      get_result($urandom_range(0, 2));
    end

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
